// File: rtl/plc_pkg.sv
// Shared types and helpers for the DCO phase loop controller.
// Optional brake path in the top is enabled by PLC_BRAKE_EN.
package plc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FACQ  = 2'd1,
    TRACK = 2'd2
  } plc_state_e;

  localparam int NUM_STAGES_DEF = 8;

  function automatic logic signed [32:0] add33(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    return {a[31], a} + {b[31], b};
  endfunction

  function automatic logic signed [31:0] sat32(
    input logic signed [32:0] v,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi
  );
    if (v < $signed({lo[31], lo}))
      return lo;
    else if (v > $signed({hi[31], hi}))
      return hi;
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/plc_lock_det.sv
// Phase lock detector: counts consecutive in-tolerance phase errors
// and raises locked once the run length reaches CNT.
module plc_lock_det
  import plc_pkg::*;
#(
  parameter int TOL = 8,
  parameter int CNT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic signed [31:0] perr,
  output logic               locked
);

  localparam int CW = $clog2(CNT + 1);

  logic [CW-1:0] lcnt_q, lcnt_d;
  logic          locked_q, locked_d;
  logic          inb;

  assign inb = (perr <= TOL) && (perr >= -TOL);

  always_comb begin
    lcnt_d   = lcnt_q;
    locked_d = locked_q;
    if (clr) begin
      lcnt_d   = '0;
      locked_d = 1'b0;
    end else if (en) begin
      if (!inb)
        lcnt_d = '0;
      else if (lcnt_q != CW'(CNT))
        lcnt_d = lcnt_q + CW'(1);
      locked_d = (lcnt_d == CW'(CNT));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      lcnt_q   <= lcnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/phase_loop_ctrl.sv
// DCO phase loop: coarse frequency acquisition then PI phase tracking.
// Define PLC_BRAKE_EN to let brake pull the per-sample phase target down.
module phase_loop_ctrl
  import plc_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int KF_SHIFT   = 2,
  parameter int KP_SHIFT   = 1,
  parameter int KI_SHIFT   = 4,
  parameter int DCTRL_MIN  = -200000,
  parameter int DCTRL_MAX  = 200000,
  parameter int FLOCK_TOL  = 4,
  parameter int FLOCK_CNT  = 8,
  parameter int PLOCK_TOL  = 8,
  parameter int LOCK_CNT   = 16,
  parameter int RELOCK_TOL = 4096,
  parameter int BRAKE_DIV  = 160
) (
  input  logic               refclk,
  input  logic               reset,
  input  logic signed [31:0] divn,
  input  logic               brake,
  input  logic signed [31:0] dco_phase,
  input  logic               phase_valid,
  output logic signed [31:0] dctrl,
  output logic signed [31:0] err,
  output logic               locked,
  output logic [1:0]         state
);

  localparam int FW = $clog2(FLOCK_CNT + 1);
  localparam logic signed [31:0] MUL = 32'(2 * NUM_STAGES);
  localparam logic signed [31:0] LO  = 32'(DCTRL_MIN);
  localparam logic signed [31:0] HI  = 32'(DCTRL_MAX);

  plc_state_e         state_q, state_d;
  logic signed [31:0] dctrl_q, dctrl_d;
  logic signed [31:0] err_q, err_d;
  logic signed [31:0] integ_q, integ_d;
  logic signed [31:0] targ_q, targ_d;
  logic signed [31:0] m1_q, m1_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;

  logic signed [31:0] ft_base, ft;
  logic signed [31:0] ferr, perr;
  logic signed [31:0] facq_dctrl;
  logic signed [31:0] trk_integ, trk_dctrl;
  logic               fin, relock;
  logic               lock_en, lock_clr;

  assign ft_base = MUL * divn;

`ifdef PLC_BRAKE_EN
  assign ft = brake ? ft_base - 32'(BRAKE_DIV) : ft_base;
`else
  logic unused_brake;
  assign unused_brake = brake;
  assign ft = ft_base;
`endif

  assign ferr = ft - (dco_phase - m1_q);
  assign perr = targ_q - dco_phase;

  assign fin    = (ferr <= FLOCK_TOL) && (ferr >= -FLOCK_TOL);
  assign relock = (perr > RELOCK_TOL) || (perr < -RELOCK_TOL);

  assign facq_dctrl = sat32(add33(dctrl_q, ferr >>> KF_SHIFT), LO, HI);
  assign trk_integ  = sat32(add33(integ_q, perr >>> KI_SHIFT), LO, HI);
  assign trk_dctrl  = sat32(add33(trk_integ, perr >>> KP_SHIFT), LO, HI);

  always_comb begin
    state_d  = state_q;
    dctrl_d  = dctrl_q;
    err_d    = err_q;
    integ_d  = integ_q;
    targ_d   = targ_q;
    m1_d     = m1_q;
    fcnt_d   = fcnt_q;
    lock_en  = 1'b0;
    lock_clr = 1'b0;
    if (phase_valid) begin
      unique case (1'b1)
        (state_q == IDLE): begin
          targ_d  = dco_phase + ft;
          m1_d    = dco_phase;
          state_d = FACQ;
        end
        (state_q == FACQ): begin
          dctrl_d = facq_dctrl;
          err_d   = ferr;
          m1_d    = dco_phase;
          targ_d  = targ_q + ft;
          fcnt_d  = fin ? fcnt_q + FW'(1) : '0;
          if (fin && fcnt_q == FW'(FLOCK_CNT - 1)) begin
            state_d = TRACK;
            integ_d = facq_dctrl;
            targ_d  = dco_phase + ft;
            fcnt_d  = '0;
          end
        end
        (state_q == TRACK): begin
          err_d  = perr;
          targ_d = targ_q + ft;
          m1_d   = dco_phase;
          if (relock) begin
            // Large slip: fall back to acquisition, keep integrator.
            state_d  = FACQ;
            lock_clr = 1'b1;
          end else begin
            integ_d = trk_integ;
            dctrl_d = trk_dctrl;
            lock_en = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q <= IDLE;
      dctrl_q <= '0;
      err_q   <= '0;
      integ_q <= '0;
      targ_q  <= '0;
      m1_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dctrl_q <= dctrl_d;
      err_q   <= err_d;
      integ_q <= integ_d;
      targ_q  <= targ_d;
      m1_q    <= m1_d;
      fcnt_q  <= fcnt_d;
    end
  end

  plc_lock_det #(
    .TOL (PLOCK_TOL),
    .CNT (LOCK_CNT)
  ) u_lock (
    .clk    (refclk),
    .reset  (reset),
    .en     (lock_en),
    .clr    (lock_clr),
    .perr   (perr),
    .locked (locked)
  );

  assign dctrl = dctrl_q;
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_phase_loop_ctrl.sv
// Scoreboard bench for phase_loop_ctrl: directed samples push expected
// outputs; a monitor compares them the cycle after each sample.
module tb_phase_loop_ctrl;

  logic               refclk = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] divn = 32'sd100;
  logic               brake = 1'b0;
  logic signed [31:0] dco_phase = '0;
  logic               phase_valid = 1'b0;
  logic signed [31:0] dctrl;
  logic signed [31:0] err;
  logic               locked;
  logic [1:0]         state;

  phase_loop_ctrl dut (
    .refclk      (refclk),
    .reset       (reset),
    .divn        (divn),
    .brake       (brake),
    .dco_phase   (dco_phase),
    .phase_valid (phase_valid),
    .dctrl       (dctrl),
    .err         (err),
    .locked      (locked),
    .state       (state)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] e;
    logic        l;
    logic [1:0]  s;
    logic [3:0]  m;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic pv_d = 1'b0;

  localparam logic [3:0] ALL = 4'b1111;
  localparam logic [3:0] NOD = 4'b0111;

  always @(posedge refclk) pv_d <= phase_valid;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t",
               n, $signed(a), $signed(r), $time);
    end
  endtask

  always @(negedge refclk) begin
    if (pv_d) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample at %0t", $time);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (x.m[3]) chk("dctrl", dctrl, x.d);
        if (x.m[2]) chk("err", err, x.e);
        if (x.m[1]) chk("locked", {31'd0, locked}, {31'd0, x.l});
        if (x.m[0]) chk("state", {30'd0, state}, {30'd0, x.s});
      end
    end
  end

  task automatic smp(input logic [31:0] ph, input logic [31:0] d,
                     input logic [31:0] e, input logic l,
                     input logic [1:0] s, input logic [3:0] m);
    exp_t x;
    x = '{d: d, e: e, l: l, s: s, m: m};
    @(posedge refclk);
    #1;
    dco_phase   = ph;
    phase_valid = 1'b1;
    q.push_back(x);
    @(posedge refclk);
    #1;
    phase_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge refclk);
    #1;
    reset = 1'b1;
    @(posedge refclk);
    #1;
    reset = 1'b0;
  endtask

  logic [31:0] ph;
  logic [31:0] tgt;
  logic [31:0] p0;

  initial begin
    // reset with phase_valid pulsing
    repeat (2) @(posedge refclk);
    smp(32'd1234, 0, 0, 1'b0, 2'd0, ALL);
    smp(32'd1234, 0, 0, 1'b0, 2'd0, ALL);
    @(posedge refclk);
    #1;
    reset = 1'b0;

    // IDLE -> FACQ
    smp(32'd1000, 0, 0, 1'b0, 2'd1, ALL);
    ph = 32'd1000;
    for (int i = 1; i <= 4; i++) begin
      ph = ph + 32'd1500;
      smp(ph, 32'(25 * i), 32'd100, 1'b0, 2'd1, ALL);
    end
    for (int i = 1; i <= 8; i++) begin
      ph = ph + 32'd1600;
      smp(ph, 32'd100, 32'd0, 1'b0, (i == 8) ? 2'd2 : 2'd1, ALL);
    end

    // tracking: exact target for 16 samples
    tgt = 32'd21400;
    for (int j = 0; j < 16; j++) begin
      smp(tgt, 32'd100, 32'd0, (j == 15), 2'd2, ALL);
      tgt = tgt + 32'd1600;
    end
    smp(tgt - 32'd300, 32'd268, 32'd300, 1'b0, 2'd2, ALL);
    tgt = tgt + 32'd1600;
    smp(tgt, 32'd118, 32'd0, 1'b0, 2'd2, ALL);
    tgt = tgt + 32'd1600;
    smp(tgt + 32'd100, 32'd61, 32'hFFFF_FF9C, 1'b0, 2'd2, ALL);
    tgt = tgt + 32'd1600;
    smp(tgt - 32'd4096, 32'd2415, 32'd4096, 1'b0, 2'd2, ALL);
    tgt = tgt + 32'd1600;
    smp(tgt - 32'd5000, 0, 32'd5000, 1'b0, 2'd1, NOD);

    // reset wins over a valid sample
    @(posedge refclk);
    #1;
    reset = 1'b1;
    smp(32'd77, 0, 0, 1'b0, 2'd0, ALL);
    @(posedge refclk);
    #1;
    reset = 1'b0;

    // lock then track across the 2^31-1 -> -2^31 wrap
    p0 = 32'd2147439947;
    smp(p0, 0, 0, 1'b0, 2'd1, ALL);
    for (int k = 1; k <= 8; k++)
      smp(p0 + 32'(1600 * k), 0, 0, 1'b0,
          (k == 8) ? 2'd2 : 2'd1, ALL);
    tgt = p0 + 32'd14400;
    for (int j = 0; j < 22; j++) begin
      smp(tgt, 0, 0, (j >= 15), 2'd2, ALL);
      tgt = tgt + 32'd1600;
    end

    // dctrl saturation in FACQ
    do_reset();
    smp(32'd0, 0, 0, 1'b0, 2'd1, ALL);
    ph = 32'd1600 - 32'd1048576;
    smp(ph, 32'd200000, 32'd1048576, 1'b0, 2'd1, ALL);
    ph = ph + 32'd1600 - 32'd1048576;
    smp(ph, 32'd200000, 32'd1048576, 1'b0, 2'd1, ALL);
    ph = ph + 32'd1600 + 32'd4194304;
    smp(ph, 32'hFFFC_F2C0, 32'hFFC0_0000, 1'b0, 2'd1, ALL);

    // brake request
    do_reset();
    brake = 1'b1;
    smp(32'd0, 0, 0, 1'b0, 2'd1, ALL);
`ifdef PLC_BRAKE_EN
    smp(32'd1440, 0, 0, 1'b0, 2'd1, ALL);
`else
    smp(32'd1440, 32'd40, 32'd160, 1'b0, 2'd1, ALL);
`endif
    brake = 1'b0;

    repeat (4) @(posedge refclk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_expect got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_loop_ctrl.md
Name: phase_loop_ctrl

Overview:
- Digital loop controller that closes the DCO phase-sampling loop.
- Consumes the sampled DCO phase word (count of stage transitions) once per reference cycle and produces the DCO control code `dctrl`.
- Does coarse frequency acquisition, then a PI phase-tracking loop with lock detection.
- Sits between the DCO phase sampler (its `dco_phase` output) and the DCO frequency input (`dctrl`).

Parameters:
- NUM_STAGES, 8, DCO ring stages; one DCO period = 2*NUM_STAGES phase units.
- KF_SHIFT, 2, arithmetic right-shift applied to frequency error in acquisition.
- KP_SHIFT, 1, proportional-path shift in tracking.
- KI_SHIFT, 4, integral-path shift in tracking.
- DCTRL_MIN, -200000, lower saturation of dctrl and integrator.
- DCTRL_MAX, 200000, upper saturation of dctrl and integrator.
- FLOCK_TOL, 4, |freq error| bound for frequency lock.
- FLOCK_CNT, 8, consecutive in-bound samples to leave acquisition.
- PLOCK_TOL, 8, |phase error| bound for phase lock.
- LOCK_CNT, 16, consecutive in-bound samples to assert locked.
- RELOCK_TOL, 4096, |phase error| that forces return to acquisition.
- BRAKE_DIV, 160, phase units per sample removed from target when braking.

Ports:
- refclk  in  1  reference clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- divn  in  32 signed  feedback divide ratio.
- brake  in  1  brake request; ignored unless PLC_BRAKE_EN is defined.
- dco_phase  in  32 signed  sampled DCO phase word.
- phase_valid  in  1  dco_phase is a new sample this cycle.
- dctrl  out  32 signed  DCO control code, registered.
- err  out  32 signed  last computed error (freq or phase per state), registered.
- locked  out  1  phase lock indicator, registered.
- state  out  2  current FSM state, for debug.

Behaviour:
- Clocking and reset: one clock, refclk. Reset is synchronous and active-high.
- Reset (rising edge with reset=1):
  - state=IDLE, dctrl=0, err=0, locked=0.
  - integ=0, targ_phase=0, phase_m1=0, all counters=0.
  - Reset mid-operation wins over any phase_valid in the same cycle.
- freq_target = 2*NUM_STAGES*divn, combinational; takes effect at the next valid sample.
- Arithmetic:
  - All phase arithmetic is 32-bit two's complement and wraps modulo 2^32.
  - Differences are taken as signed 32-bit, so a dco_phase wrap at 2^31-1 → -2^31 produces correct small errors.
  - Shifts are arithmetic.
  - Adds into dctrl/integ are done at 33 bits, then saturated to [DCTRL_MIN, DCTRL_MAX].
- phase_valid=0: all registers hold. Only valid samples advance the loop.
- States: IDLE=0, FACQ=1, TRACK=2.
- IDLE, on a valid sample:
  - targ_phase <= dco_phase + freq_target; phase_m1 <= dco_phase; go to FACQ.
  - dctrl unchanged.
- FACQ, on a valid sample:
  - ferr = freq_target - (dco_phase - phase_m1).
  - dctrl <= sat(dctrl + (ferr>>>KF_SHIFT)); err <= ferr.
  - phase_m1 <= dco_phase; targ_phase <= targ_phase + freq_target.
  - fcnt: if |ferr| <= FLOCK_TOL then fcnt+1, else 0.
  - When fcnt reaches FLOCK_CNT: go to TRACK, integ <= dctrl (post-update value), targ_phase <= dco_phase + freq_target (re-anchor), fcnt <= 0.
- TRACK, on a valid sample:
  - perr = targ_phase - dco_phase.
  - integ <= sat(integ + (perr>>>KI_SHIFT)).
  - dctrl <= sat(new integ + (perr>>>KP_SHIFT)); err <= perr.
  - targ_phase <= targ_phase + freq_target; phase_m1 <= dco_phase.
- Lock detection (TRACK only):
  - If |perr| <= PLOCK_TOL then lcnt+1 (saturating at LOCK_CNT), else lcnt <= 0.
  - locked <= (lcnt reaches LOCK_CNT).
  - locked drops on the first out-of-bound sample.
- Relock: if |perr| > RELOCK_TOL, go to FACQ; locked <= 0, lcnt <= 0, integ held, phase_m1 <= dco_phase.
- Latency: dctrl/err/locked reflect a sample at the rising edge on which phase_valid=1 is seen; visible the following cycle.
- divn change while locked: produces a phase ramp error; relocks via PI or via FACQ if RELOCK_TOL is exceeded.

Optional Feature:
- Macro: PLC_BRAKE_EN.
- Defined: when brake=1, freq_target = 2*NUM_STAGES*divn - BRAKE_DIV. brake is sampled with each valid sample.
- Undefined: brake port is present but ignored; freq_target is unaffected.

Decomposition:
- Package plc_pkg holds:
  - the state enum type (IDLE/FACQ/TRACK);
  - the default NUM_STAGES constant;
  - a sat32 function for 33-bit to clamped 32-bit.
- One sub-module, plc_lock_det: holds tolerance, counter and `locked` output. Instantiated with PLOCK_TOL/LOCK_CNT, fed perr and a sample-enable.

Test Plan:
- Reset: reset=1 with phase_valid pulsing, dco_phase=1234 → dctrl=0, err=0, locked=0, state=0 throughout.
- Initialisation: divn=100 (freq_target=1600), first sample dco_phase=1000 → state=1, internal targ_phase=2600, dctrl=0.
- Acquisition: samples stepping +1500 each → ferr=100, dctrl increments by 25 per sample. Then step exactly 1600 for 8 samples → state=2 after the 8th.
- Tracking and lock:
  - dco_phase exactly equals targ_phase for 16 samples → err=0, locked=1 after the 16th sample.
  - One sample offset -300 → err=300, locked=0 next cycle.
  - Offset 5000 → state=1.
- Wrap and saturation:
  - Tracked phase crossing 2^31-1 → err=0, locked stays 1.
  - Forced ferr=2^20 in FACQ → dctrl clamps at 200000.
- Brake (PLC_BRAKE_EN defined): brake=1, divn=100, phase steps 1440 in FACQ → ferr=0. Same run with the macro undefined → ferr=160.
